// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction memory, IF/ID and redirect signals of the fetch unit
// master: the fetch unit; slave: memory, decode and redirect sources seen together.
interface inst_fetch_unit_if #(
  parameter int PCL = 32
) ();
  logic [PCL-1:0] imem_addr;
  logic [31:0]    imem_data;
  logic           if_valid;
  logic [31:0]    if_inst;
  logic [PCL-1:0] if_pc4;
  logic           id_ready;
  logic           redirect_valid;
  logic [PCL-1:0] redirect_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output if_valid,
    output if_inst,
    output if_pc4,
    input  id_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  if_valid,
    input  if_inst,
    input  if_pc4,
    output id_ready,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC owner and prefetch queue feeding decode
// Optional FETCH_ALIGN_CHECK_EN: force redirect targets to word alignment and pulse misalign_err.
module inst_fetch_unit #(
  parameter int             PCL      = 32,
  parameter logic [PCL-1:0] RESET_PC = '0,
  parameter logic [31:0]    NOP_INST = 32'h0000_0000,
  parameter int             DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_fetch_unit_if.master bus,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic [15:0]       fetch_count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  logic [31:0]    inst_q [DEPTH];
  logic [PCL-1:0] pc4_q  [DEPTH];

  logic [PCL-1:0] pc_q, pc_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    fcnt_q, fcnt_d;
  logic [PCL-1:0] pc_plus4;
  logic [PCL-1:0] redirect_tgt;
  logic           head_valid;
  logic           deq;
  logic           push;

  assign head_valid = (count_q != '0);
  assign pc_plus4   = pc_q + PCL'(4);

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign redirect_tgt = {bus.redirect_pc[PCL-1:2], 2'b00};
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign redirect_tgt = bus.redirect_pc;
`endif

  always_comb begin
    deq      = head_valid && bus.id_ready;
    push     = !bus.redirect_valid && ((count_q < CW'(DEPTH)) || deq);
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fcnt_d   = fcnt_q;
    if (bus.redirect_valid) begin
      // A handshake this cycle is consumed by decode, but the queue is flushed anyway.
      pc_d     = redirect_tgt;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_plus4;
        wr_ptr_d = wr_ptr_q + PW'(1);
        fcnt_d   = fcnt_q + 16'd1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Entry storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr_q] <= bus.imem_data;
      pc4_q[wr_ptr_q]  <= pc_plus4;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = head_valid;
  assign bus.if_inst   = head_valid ? inst_q[rd_ptr_q] : NOP_INST;
  assign bus.if_pc4    = head_valid ? pc4_q[rd_ptr_q] : '0;
  assign fetch_count   = fcnt_q;

endmodule
